// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in, serial-out transmitter.
// Takes a WIDTH-bit word over a valid/ready handshake and shifts it out
// MSB-first on dout, holding each bit for CLKS_PER_BIT enabled cycles.
// bit_strobe marks the final cycle of each bit so a left-shift SIPO
// receiver (enable=bit_strobe, din=dout) rebuilds the word after WIDTH
// strobes. A word offered during the last-bit strobe is taken with no gap.
module piso_serializer #(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             dout,
  output logic             bit_strobe,
  output logic             busy,
  output logic             done
);

  // Reject parameter values that cannot form a frame.
  if (WIDTH < 2 || CLKS_PER_BIT < 1) begin : g_bad_params
    $error("piso_serializer: WIDTH must be >= 2 and CLKS_PER_BIT must be >= 1");
  end

  // Bit counter spans 0..WIDTH-1; divider spans 0..CLKS_PER_BIT-1.
  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DCW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);
  localparam logic [DCW-1:0] LAST_DIV = DCW'(CLKS_PER_BIT - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BCW-1:0]   bit_q, bit_d;
  logic [DCW-1:0]   div_q, div_d;
  logic             last_bit;
  logic             accept;

  // The shift register is all zeros whenever the FSM is idle (cleared by
  // reset, fully shifted out at frame end), so its MSB doubles as dout.
  assign dout = shift_q[WIDTH-1];
  assign busy = (state_q == SHIFT);

  // Next-state, handshake and strobe decode.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    shift_d    = shift_q;
    bit_d      = bit_q;
    div_d      = div_q;
    bit_strobe = 1'b0;
    last_bit   = 1'b0;
    load_ready = 1'b0;
    accept     = 1'b0;

    case (state_q)
      IDLE: begin
        load_ready = ~rst;
        accept     = load_valid & load_ready & enable;
        if (accept) begin
          state_d = SHIFT;
          shift_d = load_data;
          bit_d   = '0;
          div_d   = '0;
        end
      end

      SHIFT: begin
        bit_strobe = enable && (div_q == LAST_DIV);
        last_bit   = bit_strobe && (bit_q == LAST_BIT);
        load_ready = last_bit;
        accept     = last_bit & load_valid;
        if (enable) begin
          if (!bit_strobe) begin
            div_d = div_q + 1'b1;
          end else if (accept) begin
            // Back-to-back frame: reload and keep shifting without a gap.
            shift_d = load_data;
            bit_d   = '0;
            div_d   = '0;
          end else begin
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
            div_d   = '0;
            if (last_bit) begin
              bit_d   = '0;
              state_d = IDLE;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      done    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge value of its neighbours.
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      done    <= last_bit;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: drives two serializers (CLKS_PER_BIT = 1 and 3) from
// the same inputs and compares every output, every cycle, against a model
// that tracks each frame as "enabled cycles elapsed since the handshake".
// A SIPO receiver model per instance rebuilds the transmitted words.
module tb_piso_serializer;

  localparam int W     = 4;
  localparam int CPB_A = 1;
  localparam int CPB_B = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         load_valid;
  logic [W-1:0] load_data;

  logic ready_a, dout_a, strobe_a, busy_a, done_a;
  logic ready_b, dout_b, strobe_b, busy_b, done_b;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .CLKS_PER_BIT(CPB_A)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (ready_a),
    .dout       (dout_a),
    .bit_strobe (strobe_a),
    .busy       (busy_a),
    .done       (done_a)
  );

  piso_serializer #(.WIDTH(W), .CLKS_PER_BIT(CPB_B)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (ready_b),
    .dout       (dout_b),
    .bit_strobe (strobe_b),
    .busy       (busy_b),
    .done       (done_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model, index 0 = dut_a, 1 = dut_b.
  int           cpb [2] = '{CPB_A, CPB_B};
  bit           m_active [2];
  int           m_pos [2];
  logic [W-1:0] m_word [2];
  bit           m_done [2];

  // Receiver model and per-scenario statistics.
  logic [7:0]   sipo [2];
  int           n_done [2];
  int           n_busy [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {load_ready, dout, bit_strobe, busy, done} for instance i.
  function automatic logic [4:0] predict(input int i);
    logic d, s, l, r;
    if (rst) return 5'b0;
    d = m_active[i] ? m_word[i][W-1 - m_pos[i] / cpb[i]] : 1'b0;
    s = m_active[i] && enable && (m_pos[i] % cpb[i] == cpb[i] - 1);
    l = s && (m_pos[i] / cpb[i] == W - 1);
    r = !m_active[i] || l;
    return {r, d, s, m_active[i], m_done[i]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_active[i] = 1'b0;
      m_pos[i]    = 0;
      m_word[i]   = '0;
      m_done[i]   = 1'b0;
    end
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 2; i++) begin
      sipo[i]   = '0;
      n_done[i] = 0;
      n_busy[i] = 0;
    end
  endtask

  // One clock: check outputs at the falling edge, advance the model at the
  // rising edge, return just after it so the caller can change inputs.
  task automatic step();
    logic [4:0] e, o;
    logic       last_now;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      e = predict(i);
      o = (i == 0) ? {ready_a, dout_a, strobe_a, busy_a, done_a}
                   : {ready_b, dout_b, strobe_b, busy_b, done_b};
      check($sformatf("load_ready_%0d", i), 32'(o[4]), 32'(e[4]));
      check($sformatf("dout_%0d", i),       32'(o[3]), 32'(e[3]));
      check($sformatf("bit_strobe_%0d", i), 32'(o[2]), 32'(e[2]));
      check($sformatf("busy_%0d", i),       32'(o[1]), 32'(e[1]));
      check($sformatf("done_%0d", i),       32'(o[0]), 32'(e[0]));
      if (rst)       sipo[i] = '0;
      else if (o[2]) sipo[i] = {sipo[i][6:0], o[3]};
      if (o[0]) n_done[i]++;
      if (o[1]) n_busy[i]++;
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_active[i] = 1'b0;
        m_pos[i]    = 0;
        m_done[i]   = 1'b0;
      end else begin
        e        = predict(i);
        last_now = e[2] && (m_pos[i] / cpb[i] == W - 1);
        m_done[i] = last_now;
        if (enable) begin
          if (!m_active[i]) begin
            if (load_valid) begin
              m_active[i] = 1'b1;
              m_pos[i]    = 0;
              m_word[i]   = load_data;
            end
          end else if (last_now) begin
            if (load_valid) begin
              m_pos[i]  = 0;
              m_word[i] = load_data;
            end else begin
              m_active[i] = 1'b0;
            end
          end else begin
            m_pos[i]++;
          end
        end
      end
    end
    #1;
  endtask

  // Run until both model frames have ended, then two more cycles so the
  // trailing done pulse is observed.
  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while ((m_active[0] || m_active[1]) && n < max_cycles) begin
      step();
      n++;
    end
    check("wait_idle_bound", 32'(m_active[0] || m_active[1]), 32'd0);
    step();
    step();
  endtask

  task automatic send(input logic [W-1:0] word);
    load_data  = word;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] w;

    rst        = 1'b1;
    enable     = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    model_clear();
    clear_stats();

    // Reset state.
    #1;
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_dout_b", 32'(dout_b), 32'd0);
    step();
    step();
    rst    = 1'b0;
    enable = 1'b1;
    #1;
    check("ready_after_rst_a", 32'(ready_a), 32'd1);
    check("ready_after_rst_b", 32'(ready_b), 32'd1);
    step();

    // Single frame 1011.
    clear_stats();
    send(4'b1011);
    wait_idle(40);
    check("s1_q_a",    32'(sipo[0][3:0]), 32'hB);
    check("s1_q_b",    32'(sipo[1][3:0]), 32'hB);
    check("s1_done_a", 32'(n_done[0]), 32'd1);
    check("s1_done_b", 32'(n_done[1]), 32'd1);
    check("s1_busy_a", 32'(n_busy[0]), 32'd4);
    check("s1_busy_b", 32'(n_busy[1]), 32'd12);

    // Single frame 0110, three clocks per bit on dut_b.
    clear_stats();
    send(4'b0110);
    wait_idle(40);
    check("s2_q_b",    32'(sipo[1][3:0]), 32'h6);
    check("s2_busy_b", 32'(n_busy[1]), 32'd12);
    check("s2_done_b", 32'(n_done[1]), 32'd1);
    check("s2_q_a",    32'(sipo[0][3:0]), 32'h6);

    // Back-to-back A then 5 with load_valid held through the last bit.
    clear_stats();
    load_data  = 4'hA;
    load_valid = 1'b1;
    step();
    load_data  = 4'h5;
    repeat (4) step();
    load_valid = 1'b0;
    load_data  = '0;
    wait_idle(60);
    check("b2b_stream_a", 32'(sipo[0]), 32'hA5);
    check("b2b_busy_a",   32'(n_busy[0]), 32'd8);
    check("b2b_done_a",   32'(n_done[0]), 32'd2);
    check("b2b_q_b",      32'(sipo[1][3:0]), 32'hA);
    check("b2b_done_b",   32'(n_done[1]), 32'd1);

    // Enable low for five cycles after two bits.
    clear_stats();
    w = W'($urandom);
    send(w);
    step();
    step();
    enable = 1'b0;
    #1;
    check("en_hold_dout_a", 32'(dout_a), 32'(w[1]));
    repeat (5) step();
    check("en_hold_dout_a_end", 32'(dout_a), 32'(w[1]));
    enable = 1'b1;
    wait_idle(60);
    check("en_q_a",    32'(sipo[0][3:0]), 32'(w));
    check("en_busy_a", 32'(n_busy[0]), 32'd9);
    check("en_busy_b", 32'(n_busy[1]), 32'd17);
    check("en_done_a", 32'(n_done[0]), 32'd1);
    check("en_q_b",    32'(sipo[1][3:0]), 32'(w));

    // Reset mid-frame, then a clean frame.
    clear_stats();
    send(4'b1100);
    step();
    step();
    rst = 1'b1;
    #1;
    check("abort_busy_a", 32'(busy_a), 32'd0);
    check("abort_dout_a", 32'(dout_a), 32'd0);
    check("abort_done_a", 32'(done_a), 32'd0);
    step();
    rst = 1'b0;
    step();
    check("abort_no_done_a", 32'(n_done[0]), 32'd0);
    check("abort_ready_a",   32'(ready_a), 32'd1);
    clear_stats();
    send(4'b0011);
    wait_idle(40);
    check("post_rst_q_a",    32'(sipo[0][3:0]), 32'h3);
    check("post_rst_q_b",    32'(sipo[1][3:0]), 32'h3);
    check("post_rst_done_a", 32'(n_done[0]), 32'd1);

    // Load attempt mid-frame is ignored.
    clear_stats();
    w = W'($urandom);
    send(w);
    step();
    load_data  = 4'hF;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    load_data  = '0;
    wait_idle(40);
    check("ignore_q_a",    32'(sipo[0][3:0]), 32'(w));
    check("ignore_q_b",    32'(sipo[1][3:0]), 32'(w));
    check("ignore_done_a", 32'(n_done[0]), 32'd1);
    check("ignore_idle_a", 32'(busy_a), 32'd0);

    // Random traffic with occasional stalls and resets.
    for (int k = 0; k < 400; k++) begin
      enable     = ($urandom % 8) != 0;
      load_valid = ($urandom % 3) != 0;
      load_data  = W'($urandom);
      rst        = ($urandom % 120) == 0;
      step();
    end
    rst        = 1'b0;
    enable     = 1'b1;
    load_valid = 1'b0;
    wait_idle(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
